vproc_mem_responder: RTL and testbench
======================================

# vproc_mem_responder

On-chip scratchpad memory that acts as the responder on the vector processor's data/instruction memory bus: it accepts the request stream issued by `vproc_top` (req/addr/we/be/wdata) and returns in-order responses (rvalid/err/rdata) after a fixed pipeline latency. It sits between `vproc_top` and the `mmu` address decode, servicing the scratchpad window locally. It also exposes a word-wide backdoor load port used while the chip is in programming mode.

## Interface
- `MEM_W`, 32: bus data width in bits; power of two, ≥32.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first scratchpad word; MEM_W/8-aligned.
- `SIZE_BYTES`, 4096: scratchpad size in bytes; power of two, multiple of MEM_W/8.
- `LATENCY`, 1: cycles from request acceptance to response; 1..4.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_req_i` in 1: request valid. Always accepted, with no stall.
- `mem_addr_i` in 32: byte address.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_be_i` in MEM_W/8: byte enables for writes. Ignored for reads.
- `mem_wdata_i` in MEM_W: write data.
- `mem_rvalid_o` out 1: response valid. One response per accepted request, reads and writes alike.
- `mem_err_o` out 1: response error; qualified by `mem_rvalid_o`.
- `mem_rdata_o` out MEM_W: read data; 0 for writes and errors.
- `prog_mode_i` in 1: programming mode; level, synchronous to `clk`.
- `prog_we_i` in 1: backdoor full-word write strobe.
- `prog_addr_i` in 32: backdoor byte address.
- `prog_wdata_i` in MEM_W: backdoor write data.

## Operation
- Storage is SIZE_BYTES/(MEM_W/8) words. Contents are not reset and are X until written.
- Acceptance: a request is accepted on each rising edge where `mem_req_i`=1.
- Offset and index: offset = addr − BASE_ADDR, computed in 32-bit unsigned arithmetic. Word index = offset >> log2(MEM_W/8).
- Error conditions. A bus request is flagged err if any of the following holds:
  - offset ≥ SIZE_BYTES; this covers addr < BASE_ADDR through unsigned wrap;
  - addr[log2(MEM_W/8)−1:0] ≠ 0 (misaligned);
  - `prog_mode_i`=1.
- An errored request never modifies memory.
- Valid write: bytes with `mem_be_i[k]`=1 are updated at the acceptance edge; all other bytes are unchanged. `be`=0 is legal: no update, and the response still has err=0.
- Valid read: the word is sampled at the acceptance edge, after any write committed in an earlier cycle. Read-after-write back-to-back returns the new data.
- Response pipeline: a LATENCY-deep shift register of {valid, err, rdata}. Responses are strictly in order, one per accepted request, and there are no bubbles other than those present in the request stream.
- Backdoor port:
  - When `prog_mode_i`=1 and `prog_we_i`=1 with an in-range, aligned `prog_addr_i`, the full word is written at that edge.
  - Out-of-range or misaligned backdoor writes are silently dropped.
  - `prog_we_i` is ignored when `prog_mode_i`=0.
- Simultaneous bus request and backdoor write in the same cycle: only possible when `prog_mode_i`=1. The bus request errors and the backdoor write commits, so there is no port conflict.
- Mode switch: a request accepted in a cycle with `prog_mode_i`=1 errors even if responses for earlier requests are still in flight. In-flight responses are unaffected by later mode changes.

## Timing
- Reset asserted (`rst`=0): `mem_rvalid_o`=0, `mem_err_o`=0, `mem_rdata_o`=0 immediately and asynchronously. All pipeline valid bits are cleared.
- Reset mid-operation: in-flight responses are discarded and are never delivered. Memory writes already committed persist.
- Latency: request accepted at edge N → `mem_rvalid_o`=1 during the cycle after edge N+LATENCY−1. With LATENCY=1, the response is visible the cycle after the request.
- Throughput: one request per cycle, sustained indefinitely.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- `mem_rdata_o` and `mem_err_o` are 0 whenever `mem_rvalid_o`=0.

## Test plan
- **Reset:** hold `rst`=0 with `mem_req_i`=1 → all outputs 0. Release reset, read addr 0x0 at LATENCY=1 → rvalid=1, err=0 one cycle later.
- **Write then read:** write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 in the next cycle → write response rvalid=1 with rdata=0. Read response rdata=0xDEADBEEF.
- **Byte enables:** write 0x11223344 to 0x20 with be=4'hF, then write 0xAABBCCDD with be=4'b0101, then read 0x20 → 0x11BB33DD.
- **Boundary addresses:**
  - read 0xFFC → err=0;
  - read 0x1000 → err=1, rdata=0;
  - read 0x0002 → err=1;
  - with BASE_ADDR=0x100, read 0x0FC → err=1.
- **Streaming at LATENCY=3:** issue 8 back-to-back reads of pre-loaded 0x0..0x1C → 8 consecutive rvalid cycles starting 3 cycles after the first request, data in order.
- **Programming mode:** set `prog_mode_i`=1, backdoor-write 0xCAFEF00D to 0x40 while a bus read of 0x40 is issued the same cycle → bus response err=1. Drop `prog_mode_i`, read 0x40 → 0xCAFEF00D. Reset during a 3-deep in-flight burst → no rvalid after reset release.

Source files
------------

// File: rtl/vproc_mem_responder.sv
// Scratchpad responder for the vproc memory bus: in-order responses after a fixed
// LATENCY, with a word-wide backdoor write port that is usable only in programming mode.
module vproc_mem_responder #(
  parameter int unsigned MEM_W      = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned SIZE_BYTES = 4096,
  parameter int unsigned LATENCY    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_i,
  input  logic [31:0]        mem_addr_i,
  input  logic               mem_we_i,
  input  logic [MEM_W/8-1:0] mem_be_i,
  input  logic [MEM_W-1:0]   mem_wdata_i,
  output logic               mem_rvalid_o,
  output logic               mem_err_o,
  output logic [MEM_W-1:0]   mem_rdata_o,
  input  logic               prog_mode_i,
  input  logic               prog_we_i,
  input  logic [31:0]        prog_addr_i,
  input  logic [MEM_W-1:0]   prog_wdata_i
);

  localparam int unsigned BYTES = MEM_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned WORDS = SIZE_BYTES / BYTES;
  localparam int unsigned IDX_W = $clog2(WORDS);

  logic [MEM_W-1:0] mem [WORDS];

  logic [31:0]      bus_off;
  logic [31:0]      prog_off;
  logic [IDX_W-1:0] bus_idx;
  logic [IDX_W-1:0] prog_idx;
  logic             bus_bad;
  logic             bus_wr;
  logic             prog_wr;

  logic             in_valid;
  logic             in_err;
  logic [MEM_W-1:0] in_rdata;

  logic             pipe_valid [LATENCY];
  logic             pipe_err   [LATENCY];
  logic [MEM_W-1:0] pipe_rdata [LATENCY];

  // Addresses below BASE_ADDR wrap to huge offsets, so one compare covers both ends.
  always_comb begin
    bus_off  = mem_addr_i - BASE_ADDR;
    prog_off = prog_addr_i - BASE_ADDR;
    bus_idx  = bus_off[OFF_W +: IDX_W];
    prog_idx = prog_off[OFF_W +: IDX_W];
    bus_bad  = prog_mode_i || (bus_off >= SIZE_BYTES) || (bus_off[OFF_W-1:0] != '0);
    bus_wr   = mem_req_i && mem_we_i && !bus_bad;
    prog_wr  = prog_mode_i && prog_we_i &&
               (prog_off < SIZE_BYTES) && (prog_off[OFF_W-1:0] == '0);
  end

  always_comb begin
    in_valid = mem_req_i;
    in_err   = mem_req_i && bus_bad;
    in_rdata = '0;
    if (mem_req_i && !bus_bad && !mem_we_i) begin
      in_rdata = mem[bus_idx];
    end
  end

  // Bus writes are always errored in programming mode, so the two writers never collide.
  always_ff @(posedge clk) begin
    if (prog_wr) begin
      mem[prog_idx] <= prog_wdata_i;
    end else if (bus_wr) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        if (mem_be_i[k]) begin
          mem[bus_idx][k*8 +: 8] <= mem_wdata_i[k*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_err[i]   <= 1'b0;
        pipe_rdata[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= in_valid;
      pipe_err[0]   <= in_err;
      pipe_rdata[0] <= in_rdata;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
    end
  end

  always_comb begin
    mem_rvalid_o = pipe_valid[LATENCY-1];
    mem_err_o    = pipe_err[LATENCY-1];
    mem_rdata_o  = pipe_rdata[LATENCY-1];
  end

endmodule

// File: tb/tb_vproc_mem_responder.sv
// Bench for vproc_mem_responder: a LATENCY=1/BASE=0 instance and a LATENCY=3/BASE=0x100
// instance share one stimulus stream and are checked against a per-instance word-array model.
module tb_vproc_mem_responder;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        prog;
    logic        pwe;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_be = '0;
  logic [31:0] mem_wdata = '0;
  logic        prog_mode = 1'b0;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_wdata = '0;

  logic        a_valid, a_err, b_valid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [33:0] rsp_a, rsp_b;

  assign rsp_a = {a_valid, a_err, a_rdata};
  assign rsp_b = {b_valid, b_err, b_rdata};

  logic [31:0] mdl [2][1024];
  rsp_t        qa[$];
  rsp_t        qb[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  vproc_mem_responder #(
    .MEM_W(32), .BASE_ADDR(32'h0000_0000), .SIZE_BYTES(4096), .LATENCY(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req), .mem_addr_i(mem_addr), .mem_we_i(mem_we),
    .mem_be_i(mem_be), .mem_wdata_i(mem_wdata),
    .mem_rvalid_o(a_valid), .mem_err_o(a_err), .mem_rdata_o(a_rdata),
    .prog_mode_i(prog_mode), .prog_we_i(prog_we),
    .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata)
  );

  vproc_mem_responder #(
    .MEM_W(32), .BASE_ADDR(32'h0000_0100), .SIZE_BYTES(4096), .LATENCY(3)
  ) dut_b (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req), .mem_addr_i(mem_addr), .mem_we_i(mem_we),
    .mem_be_i(mem_be), .mem_wdata_i(mem_wdata),
    .mem_rvalid_o(b_valid), .mem_err_o(b_err), .mem_rdata_o(b_rdata),
    .prog_mode_i(prog_mode), .prog_we_i(prog_we),
    .prog_addr_i(prog_addr), .prog_wdata_i(prog_wdata)
  );

  function automatic stim_t mk(logic req, logic [31:0] addr, logic we, logic [3:0] be,
                               logic [31:0] wdata, logic prog, logic pwe,
                               logic [31:0] paddr, logic [31:0] pwdata);
    stim_t s;
    s.req = req; s.addr = addr; s.we = we; s.be = be; s.wdata = wdata;
    s.prog = prog; s.pwe = pwe; s.paddr = paddr; s.pwdata = pwdata;
    return s;
  endfunction

  function automatic stim_t rd(logic [31:0] a);
    return mk(1'b1, a, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic stim_t wr(logic [31:0] a, logic [31:0] d, logic [3:0] be);
    return mk(1'b1, a, 1'b1, be, d, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endfunction

  // Reference: a flat word array per instance; each response is queued and popped once
  // the instance's latency has elapsed (instance b starts with two empty slots after reset).
  task automatic step(input stim_t s, output rsp_t ea, output rsp_t eb);
    logic [31:0] base, off, poff;
    rsp_t r;
    for (int d = 0; d < 2; d++) begin
      base = (d == 0) ? 32'h0 : 32'h100;
      off  = s.addr - base;
      r    = '0;
      if (s.req) begin
        r.v = 1'b1;
        if (s.prog || off >= 32'd4096 || s.addr[1:0] != 2'b00) begin
          r.e = 1'b1;
        end else if (s.we) begin
          for (int k = 0; k < 4; k++)
            if (s.be[k]) mdl[d][off[11:2]][k*8 +: 8] = s.wdata[k*8 +: 8];
        end else begin
          r.d = mdl[d][off[11:2]];
        end
      end
      if (s.prog && s.pwe) begin
        poff = s.paddr - base;
        if (poff < 32'd4096 && s.paddr[1:0] == 2'b00) mdl[d][poff[11:2]] = s.pwdata;
      end
      if (d == 0) qa.push_back(r); else qb.push_back(r);
    end
    mem_req = s.req; mem_addr = s.addr; mem_we = s.we; mem_be = s.be; mem_wdata = s.wdata;
    prog_mode = s.prog; prog_we = s.pwe; prog_addr = s.paddr; prog_wdata = s.pwdata;
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    qb.push_back('0);
    qb.push_back('0);
  endtask

  task automatic test_preload();
    rsp_t ea, eb;
    for (int w = 0; w <= 32'h10FC / 4; w++) begin
      step(mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'(w * 4), $urandom), ea, eb);
      vectors += 2;
      if (rsp_a !== ea) begin miscompares++; $display("FAIL preload dut_a got %h exp %h", rsp_a, ea); end
      if (rsp_b !== eb) begin miscompares++; $display("FAIL preload dut_b got %h exp %h", rsp_b, eb); end
    end
  endtask

  task automatic test_reset();
    stim_t t[$];
    rsp_t ea, eb;
    @(posedge clk);
    #1;
    mem_req = 1'b1; mem_addr = 32'h0; mem_we = 1'b0; prog_mode = 1'b0; prog_we = 1'b0;
    rst = 1'b0;
    #1;
    vectors += 2;
    if (rsp_a !== 34'h0) begin miscompares++; $display("FAIL reset_async dut_a got %h exp 0", rsp_a); end
    if (rsp_b !== 34'h0) begin miscompares++; $display("FAIL reset_async dut_b got %h exp 0", rsp_b); end
    @(posedge clk);
    #1;
    vectors += 2;
    if (rsp_a !== 34'h0) begin miscompares++; $display("FAIL reset_held dut_a got %h exp 0", rsp_a); end
    if (rsp_b !== 34'h0) begin miscompares++; $display("FAIL reset_held dut_b got %h exp 0", rsp_b); end
    release_reset();
    t.push_back(rd(32'h0)); t.push_back(idle()); t.push_back(idle());
    foreach (t[i]) begin
      step(t[i], ea, eb);
      vectors += 2;
      if (rsp_a !== ea) begin miscompares++; $display("FAIL first_read dut_a got %h exp %h", rsp_a, ea); end
      if (rsp_b !== eb) begin miscompares++; $display("FAIL first_read dut_b got %h exp %h", rsp_b, eb); end
      if (i == 0) begin
        vectors++;
        if (rsp_a[33:32] !== 2'b10) begin
          miscompares++; $display("FAIL first_read_flags got %b exp 10", rsp_a[33:32]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    stim_t t[$];
    rsp_t ea, eb;
    t.push_back(wr(32'h110, 32'hDEADBEEF, 4'hF));
    t.push_back(rd(32'h110));
    t.push_back(wr(32'h120, 32'h11223344, 4'hF));
    t.push_back(wr(32'h120, 32'hAABBCCDD, 4'b0101));
    t.push_back(rd(32'h120));
    t.push_back(wr(32'h120, 32'h55667788, 4'h0));
    t.push_back(rd(32'h120));
    t.push_back(idle()); t.push_back(idle());
    foreach (t[i]) begin
      step(t[i], ea, eb);
      vectors += 2;
      if (rsp_a !== ea) begin miscompares++; $display("FAIL write_read dut_a got %h exp %h", rsp_a, ea); end
      if (rsp_b !== eb) begin miscompares++; $display("FAIL write_read dut_b got %h exp %h", rsp_b, eb); end
      if (i == 1 || i == 4) begin
        vectors++;
        if (rsp_a[31:0] !== ((i == 1) ? 32'hDEADBEEF : 32'h11BB33DD)) begin
          miscompares++; $display("FAIL byte_merge got %h at step %0d", rsp_a[31:0], i);
        end
      end
    end
  endtask

  task automatic test_boundary();
    stim_t t[$];
    rsp_t ea, eb;
    t.push_back(rd(32'hFFC));  t.push_back(rd(32'h1000)); t.push_back(rd(32'h10FC));
    t.push_back(rd(32'h1100)); t.push_back(rd(32'h0002)); t.push_back(rd(32'h0FC));
    t.push_back(rd(32'h100));  t.push_back(wr(32'h1000, 32'h12345678, 4'hF));
    t.push_back(rd(32'hFFFF_FFFC)); t.push_back(rd(32'h1000));
    t.push_back(idle()); t.push_back(idle());
    foreach (t[i]) begin
      step(t[i], ea, eb);
      vectors += 2;
      if (rsp_a !== ea) begin miscompares++; $display("FAIL boundary dut_a got %h exp %h", rsp_a, ea); end
      if (rsp_b !== eb) begin miscompares++; $display("FAIL boundary dut_b got %h exp %h", rsp_b, eb); end
    end
  endtask

  task automatic test_streaming();
    rsp_t ea, eb;
    for (int i = 0; i < 11; i++) begin
      step((i < 8) ? rd(32'h100 + 32'(i * 4)) : idle(), ea, eb);
      vectors += 2;
      if (rsp_a !== ea) begin miscompares++; $display("FAIL stream dut_a got %h exp %h", rsp_a, ea); end
      if (rsp_b !== eb) begin miscompares++; $display("FAIL stream dut_b got %h exp %h", rsp_b, eb); end
      vectors++;
      if (b_valid !== (i >= 2 && i < 10)) begin
        miscompares++; $display("FAIL stream_valid step %0d got %b", i, b_valid);
      end
    end
  endtask

  task automatic test_prog_mode();
    stim_t t[$];
    rsp_t ea, eb;
    t.push_back(mk(1'b1, 32'h40, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D));
    t.push_back(mk(1'b1, 32'h140, 1'b1, 4'hF, 32'h0BADBAD0, 1'b1, 1'b1, 32'h140, 32'h12345678));
    t.push_back(mk(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h14A, 32'hFFFF0000));
    t.push_back(mk(1'b1, 32'h40, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h44, 32'h0000BAD0));
    t.push_back(rd(32'h140)); t.push_back(rd(32'h44)); t.push_back(rd(32'h148));
    t.push_back(idle()); t.push_back(idle());
    foreach (t[i]) begin
      step(t[i], ea, eb);
      vectors += 2;
      if (rsp_a !== ea) begin miscompares++; $display("FAIL prog dut_a got %h exp %h", rsp_a, ea); end
      if (rsp_b !== eb) begin miscompares++; $display("FAIL prog dut_b got %h exp %h", rsp_b, eb); end
      if (i == 0 || i == 3) begin
        vectors++;
        if (rsp_a !== ((i == 0) ? 34'h2_0000_0000 | 34'h1_0000_0000 : {2'b10, 32'hCAFEF00D})) begin
          miscompares++; $display("FAIL prog_literal step %0d got %h", i, rsp_a);
        end
      end
    end
  endtask

  task automatic test_random();
    rsp_t ea, eb;
    stim_t s;
    for (int i = 0; i < 402; i++) begin
      if (i < 400) begin
        s = mk($urandom_range(0, 3) != 0, 32'($urandom_range(0, 32'h11FF)), $urandom_range(0, 1) == 1,
               4'($urandom), $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
               32'($urandom_range(0, 32'h11FF)), $urandom);
        if ($urandom_range(0, 9) != 0) s.addr[1:0] = 2'b00;
        if ($urandom_range(0, 19) == 0) s.addr = $urandom;
        if ($urandom_range(0, 3) != 0) s.paddr[1:0] = 2'b00;
      end else begin
        s = idle();
      end
      step(s, ea, eb);
      vectors += 2;
      if (rsp_a !== ea) begin miscompares++; $display("FAIL random dut_a got %h exp %h", rsp_a, ea); end
      if (rsp_b !== eb) begin miscompares++; $display("FAIL random dut_b got %h exp %h", rsp_b, eb); end
    end
  endtask

  task automatic test_reset_inflight();
    rsp_t ea, eb;
    for (int i = 0; i < 3; i++) begin
      step(rd(32'h100 + 32'(i * 4)), ea, eb);
      vectors += 2;
      if (rsp_a !== ea) begin miscompares++; $display("FAIL inflight dut_a got %h exp %h", rsp_a, ea); end
      if (rsp_b !== eb) begin miscompares++; $display("FAIL inflight dut_b got %h exp %h", rsp_b, eb); end
    end
    rst = 1'b0;
    #1;
    vectors += 2;
    if (rsp_a !== 34'h0) begin miscompares++; $display("FAIL inflight_rst dut_a got %h exp 0", rsp_a); end
    if (rsp_b !== 34'h0) begin miscompares++; $display("FAIL inflight_rst dut_b got %h exp 0", rsp_b); end
    mem_req = 1'b0;
    @(posedge clk);
    release_reset();
    for (int i = 0; i < 5; i++) begin
      step(idle(), ea, eb);
      vectors += 2;
      if (rsp_a !== ea) begin miscompares++; $display("FAIL after_rst dut_a got %h exp %h", rsp_a, ea); end
      if (rsp_b !== eb) begin miscompares++; $display("FAIL after_rst dut_b got %h exp %h", rsp_b, eb); end
    end
    step(rd(32'h104), ea, eb);
    repeat (2) step(idle(), ea, eb);
    vectors++;
    if (rsp_b !== {2'b10, mdl[1][1]}) begin
      miscompares++; $display("FAIL persist dut_b got %h exp %h", rsp_b, {2'b10, mdl[1][1]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    release_reset();
    test_preload();
    test_reset();
    test_write_read();
    test_boundary();
    test_streaming();
    test_prog_mode();
    test_random();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
